sdram_slot_scheduler: RTL and testbench
=======================================

# sdram_slot_scheduler

Slot-synchronous scheduler that shares the single SDRAM controller port among three requesters: CPU bytes, floppy/disk bytes and video read-only words. It also injects periodic auto-refresh commands. It sits between the requesters and SDRAM_Controller, and is paced by the system `access_slot` strobe. It owns the controller's single-cycle command handshake, byte-lane selection, and read-data return.

## Interface
- `REFRESH_CYCLES`, default 780: clk cycles between refresh requests (15.6 µs at 50 MHz).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `access_slot`  in  1  one-cycle strobe; new grants start only on it.
- `cpu_addr`, `disk_addr`  in  23 each  byte address.
- `cpu_wdata`, `disk_wdata`  in  8 each  write byte.
- `cpu_read`, `cpu_write`, `disk_read`, `disk_write`  in  1 each  level requests, held until ack.
- `cpu_ack`, `disk_ack`  out  1 each  one-cycle completion pulse.
- `cpu_rdata`, `disk_rdata`  out  8 each  registered read byte.
- `vid_addr`  in  22  word address.
- `vid_read`  in  1  level request, held until ack.
- `vid_ack`  out  1  one-cycle completion pulse.
- `vid_rdata`  out  16  registered read word.
- `sdram_addr`  out  22  word address to controller.
- `sdram_do`  out  16  write data to controller.
- `sdram_di`  in  16  read data from controller.
- `sdram_read`, `sdram_write`, `sdram_refresh`  out  1 each  command pulses.
- `sdram_lb`, `sdram_ub`  out  1 each  byte-lane enables.
- `sdram_busy`  in  1  controller busy.
- `refresh_late`  out  1  sticky: a refresh interval expired while one was still pending.

## Operation
- Reset state:
  - FSM in IDLE.
  - Every output is 0, including all rdata registers and `refresh_late`.
  - Refresh counter is 0 and refresh-pending is 0.
  - Round-robin pointer points at CPU.
  - A reset arriving mid-transaction abandons it with no ack.
- Refresh timer:
  - Free-running counter 0..REFRESH_CYCLES-1, wraps to 0.
  - Reaching REFRESH_CYCLES-1 sets pending.
  - If pending is already 1 at that point, `refresh_late` is set; it is cleared only by reset.
- FSM states:
  - IDLE: when `access_slot`=1, grant by priority and go to ISSUE. With no candidate, stay in IDLE.
  - ISSUE: exactly one command pulse is asserted. Pending is cleared here if the grant is refresh.
  - ARM: one cycle; `sdram_busy` is ignored.
  - WAIT: stay while `sdram_busy`=1. When it is 0, capture `sdram_di` into the granted port's rdata (reads only) and go to DONE.
  - DONE: pulse the granted port's ack (none for refresh), then go to HOLD.
  - HOLD: one cycle, then IDLE. This gives requesters one cycle to drop the request.
- Priority: refresh pending > video > CPU/disk round-robin.
  - The pointer toggles to the other byte port after each CPU or disk grant.
  - If only one byte port is requesting, it wins regardless of the pointer.
- A port with both read and write asserted is treated as a write; its ack completes both.
- Byte mapping:
  - `sdram_addr` = addr[22:1].
  - addr[0]=0 sets `sdram_lb`; addr[0]=1 sets `sdram_ub`.
  - `sdram_do` = {wdata, wdata}.
  - Read byte is `sdram_di[7:0]` when addr[0]=0, else `sdram_di[15:8]`.
- Video: `sdram_addr` = `vid_addr`; `sdram_lb` = `sdram_ub` = 1.
- Refresh: address and lane outputs are don't-care (driven 0).
- Request inputs are latched at grant. `sdram_addr`, `sdram_do`, `sdram_lb` and `sdram_ub` stay stable from ISSUE through WAIT, then return to 0 in DONE.
- rdata registers hold their value until that port's next read completes. Writes never modify rdata.

## Timing
- Grant at cycle t (IDLE with `access_slot`) → command pulse at t+1 → ARM at t+2 → WAIT from t+3.
- If busy is first seen low at cycle w (w ≥ t+3): rdata is valid and ack is high at w+1; HOLD at w+2; IDLE at w+3.
- Minimum grant-to-ack latency is 4 cycles (busy already low at t+3).
- Command outputs are registered and high for exactly one cycle per grant.
- At most one command is outstanding at any time.
- A slot strobe outside IDLE is ignored; the request waits for the next strobe.
- A refresh expiry during a transaction only sets pending; it is served at the next IDLE slot.

## Test plan
- Reset held 3 cycles mid-WAIT → all outputs 0, no ack, FSM in IDLE. Next slot with `cpu_read` → normal transaction.
- `cpu_read`, addr 0x000003; controller busy high 4 cycles after the command with `sdram_di`=0xA55A; slot at t → `sdram_read` at t+1 with `sdram_addr`=0x000001 and `sdram_ub`=1; `cpu_ack` at t+7 with `cpu_rdata`=0xA5.
- `disk_write`, addr 0x000010, data 0x3C → `sdram_write` one cycle, `sdram_do`=0x3C3C, `sdram_lb`=1, `sdram_ub`=0; `disk_ack` once; `disk_rdata` unchanged.
- CPU and disk both requesting continuously for 4 slots → grant order CPU, disk, CPU, disk; each ack exactly once per transaction.
- Video, CPU and refresh pending all at the same slot → refresh first (no ack), video next with lb=ub=1 and full 16-bit `vid_rdata`, then CPU.
- REFRESH_CYCLES=8 with the controller held busy for 20 cycles → `refresh_late`=1 and it stays 1; exactly one `sdram_refresh` is issued after busy drops.

Source files
------------

// File: rtl/sdram_slot_scheduler.sv
// sdram_slot_scheduler
// Shares one SDRAM controller command port between a CPU byte port, a
// disk byte port and a read-only video word port, and injects periodic
// auto-refresh commands. New work is only started on an access_slot strobe,
// and only one command is ever outstanding at the controller.
module sdram_slot_scheduler #(
    parameter int REFRESH_CYCLES = 780
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        access_slot,

    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,

    input  logic [22:0] disk_addr,
    input  logic [7:0]  disk_wdata,
    input  logic        disk_read,
    input  logic        disk_write,
    output logic        disk_ack,
    output logic [7:0]  disk_rdata,

    input  logic [21:0] vid_addr,
    input  logic        vid_read,
    output logic        vid_ack,
    output logic [15:0] vid_rdata,

    output logic [21:0] sdram_addr,
    output logic [15:0] sdram_do,
    input  logic [15:0] sdram_di,
    output logic        sdram_read,
    output logic        sdram_write,
    output logic        sdram_refresh,
    output logic        sdram_lb,
    output logic        sdram_ub,
    input  logic        sdram_busy,

    output logic        refresh_late
);

    // Refresh counter sizing; guard against a degenerate single-cycle interval.
    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT,
        ST_DONE,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        SRC_REFRESH,
        SRC_VIDEO,
        SRC_CPU,
        SRC_DISK
    } src_t;

    state_t           state;
    state_t           state_next;

    // Arbitration result for the current cycle (only used when a grant starts).
    logic             grant_valid;
    src_t             grant_src;
    logic [21:0]      sel_addr;
    logic [15:0]      sel_do;
    logic             sel_lb;
    logic             sel_ub;
    logic             sel_write;
    logic             sel_hi;

    // Latched description of the transaction in flight.
    src_t             src;
    logic             is_write;
    logic             byte_hi;

    // Round-robin pointer between the byte ports: 0 favours CPU, 1 favours disk.
    logic             rr_disk;

    logic [CNT_W-1:0] refresh_cnt;
    logic             refresh_pending;
    logic             refresh_expire;

    logic             cpu_req;
    logic             disk_req;
    logic             start;
    logic             finish;

    // Pick the addressed byte out of a controller word.
    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

    // Replicate a write byte on both lanes; reads drive no data.
    function automatic logic [15:0] lane_data(input logic [7:0] wdata, input logic wr);
        return wr ? {wdata, wdata} : 16'h0000;
    endfunction

    assign cpu_req        = cpu_read | cpu_write;
    assign disk_req       = disk_read | disk_write;
    assign start          = (state == ST_IDLE) && access_slot && grant_valid;
    assign finish         = (state == ST_WAIT) && !sdram_busy;
    assign refresh_expire = (refresh_cnt == CNT_LAST);

    // Priority arbitration: refresh, then video, then round-robin byte ports.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_REFRESH;
        sel_addr    = '0;
        sel_do      = '0;
        sel_lb      = 1'b0;
        sel_ub      = 1'b0;
        sel_write   = 1'b0;
        sel_hi      = 1'b0;
        if (refresh_pending) begin
            grant_valid = 1'b1;
            grant_src   = SRC_REFRESH;
        end else if (vid_read) begin
            grant_valid = 1'b1;
            grant_src   = SRC_VIDEO;
            sel_addr    = vid_addr;
            sel_lb      = 1'b1;
            sel_ub      = 1'b1;
        end else if (cpu_req && (!disk_req || !rr_disk)) begin
            grant_valid = 1'b1;
            grant_src   = SRC_CPU;
            sel_addr    = cpu_addr[22:1];
            sel_write   = cpu_write;
            sel_do      = lane_data(cpu_wdata, cpu_write);
            sel_hi      = cpu_addr[0];
            sel_lb      = ~cpu_addr[0];
            sel_ub      = cpu_addr[0];
        end else if (disk_req) begin
            grant_valid = 1'b1;
            grant_src   = SRC_DISK;
            sel_addr    = disk_addr[22:1];
            sel_write   = disk_write;
            sel_do      = lane_data(disk_wdata, disk_write);
            sel_hi      = disk_addr[0];
            sel_lb      = ~disk_addr[0];
            sel_ub      = disk_addr[0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; ARM deliberately ignores busy so the controller
    // has a cycle to raise it after the command.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_ARM;
            ST_ARM:   state_next = ST_WAIT;
            ST_WAIT:  if (!sdram_busy) state_next = ST_DONE;
            ST_DONE:  state_next = ST_HOLD;
            ST_HOLD:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Latch the granted source and its byte lane, and advance the round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            src      <= SRC_REFRESH;
            is_write <= 1'b0;
            byte_hi  <= 1'b0;
            rr_disk  <= 1'b0;
        end else if (start) begin
            src      <= grant_src;
            is_write <= sel_write;
            byte_hi  <= sel_hi;
            if (grant_src == SRC_CPU) begin
                rr_disk <= 1'b1;
            end else if (grant_src == SRC_DISK) begin
                rr_disk <= 1'b0;
            end
        end
    end

    // Controller command pulse plus address/data/lanes held from ISSUE through WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            sdram_read    <= 1'b0;
            sdram_write   <= 1'b0;
            sdram_refresh <= 1'b0;
            sdram_addr    <= '0;
            sdram_do      <= '0;
            sdram_lb      <= 1'b0;
            sdram_ub      <= 1'b0;
        end else begin
            sdram_read    <= 1'b0;
            sdram_write   <= 1'b0;
            sdram_refresh <= 1'b0;
            if (start) begin
                sdram_refresh <= (grant_src == SRC_REFRESH);
                sdram_write   <= sel_write;
                sdram_read    <= (grant_src != SRC_REFRESH) && !sel_write;
                sdram_addr    <= sel_addr;
                sdram_do      <= sel_do;
                sdram_lb      <= sel_lb;
                sdram_ub      <= sel_ub;
            end else if (finish) begin
                sdram_addr    <= '0;
                sdram_do      <= '0;
                sdram_lb      <= 1'b0;
                sdram_ub      <= 1'b0;
            end
        end
    end

    // Completion: capture read data for the granted port and pulse its ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_ack    <= 1'b0;
            disk_ack   <= 1'b0;
            vid_ack    <= 1'b0;
            cpu_rdata  <= '0;
            disk_rdata <= '0;
            vid_rdata  <= '0;
        end else begin
            cpu_ack  <= 1'b0;
            disk_ack <= 1'b0;
            vid_ack  <= 1'b0;
            if (finish) begin
                case (src)
                    SRC_CPU: begin
                        cpu_ack <= 1'b1;
                        if (!is_write) cpu_rdata <= pick_byte(sdram_di, byte_hi);
                    end
                    SRC_DISK: begin
                        disk_ack <= 1'b1;
                        if (!is_write) disk_rdata <= pick_byte(sdram_di, byte_hi);
                    end
                    SRC_VIDEO: begin
                        vid_ack   <= 1'b1;
                        vid_rdata <= sdram_di;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Free-running refresh interval timer with pending and sticky overrun flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt     <= '0;
            refresh_pending <= 1'b0;
            refresh_late    <= 1'b0;
        end else begin
            refresh_cnt <= refresh_expire ? '0 : refresh_cnt + 1'b1;
            if (refresh_expire) begin
                refresh_pending <= 1'b1;
                if (refresh_pending) refresh_late <= 1'b1;
            end else if ((state == ST_ISSUE) && (src == SRC_REFRESH)) begin
                refresh_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_slot_scheduler.sv
// Testbench for sdram_slot_scheduler: table of single transactions checked
// through command/ack scoreboards, plus directed sequences for reset during
// WAIT, byte-port round robin, refresh/video priority and refresh overrun.
module tb_sdram_slot_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        access_slot = 1'b0;
    logic [22:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [22:0] disk_addr = '0;
    logic [7:0]  disk_wdata = '0;
    logic        disk_read = 1'b0;
    logic        disk_write = 1'b0;
    logic [21:0] vid_addr = '0;
    logic        vid_read = 1'b0;
    logic [15:0] sdram_di = '0;
    logic        sdram_busy = 1'b0;

    logic        cpu_ack, disk_ack, vid_ack;
    logic [7:0]  cpu_rdata, disk_rdata;
    logic [15:0] vid_rdata;
    logic [21:0] sdram_addr;
    logic [15:0] sdram_do;
    logic        sdram_read, sdram_write, sdram_refresh, sdram_lb, sdram_ub;
    logic        refresh_late;

    logic        b_cpu_ack, b_disk_ack, b_vid_ack;
    logic [7:0]  b_cpu_rdata, b_disk_rdata;
    logic [15:0] b_vid_rdata;
    logic [21:0] b_sdram_addr;
    logic [15:0] b_sdram_do;
    logic        b_sdram_read, b_sdram_write, b_sdram_refresh, b_sdram_lb, b_sdram_ub;
    logic        b_refresh_late;

    sdram_slot_scheduler dut (
        .clk(clk), .reset(reset), .access_slot(access_slot),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .disk_addr(disk_addr), .disk_wdata(disk_wdata), .disk_read(disk_read), .disk_write(disk_write),
        .disk_ack(disk_ack), .disk_rdata(disk_rdata),
        .vid_addr(vid_addr), .vid_read(vid_read), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .sdram_addr(sdram_addr), .sdram_do(sdram_do), .sdram_di(sdram_di),
        .sdram_read(sdram_read), .sdram_write(sdram_write), .sdram_refresh(sdram_refresh),
        .sdram_lb(sdram_lb), .sdram_ub(sdram_ub), .sdram_busy(sdram_busy),
        .refresh_late(refresh_late)
    );

    sdram_slot_scheduler #(.REFRESH_CYCLES(8)) dut_fast (
        .clk(clk), .reset(reset), .access_slot(access_slot),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .disk_addr(disk_addr), .disk_wdata(disk_wdata), .disk_read(disk_read), .disk_write(disk_write),
        .disk_ack(b_disk_ack), .disk_rdata(b_disk_rdata),
        .vid_addr(vid_addr), .vid_read(vid_read), .vid_ack(b_vid_ack), .vid_rdata(b_vid_rdata),
        .sdram_addr(b_sdram_addr), .sdram_do(b_sdram_do), .sdram_di(sdram_di),
        .sdram_read(b_sdram_read), .sdram_write(b_sdram_write), .sdram_refresh(b_sdram_refresh),
        .sdram_lb(b_sdram_lb), .sdram_ub(b_sdram_ub), .sdram_busy(sdram_busy),
        .refresh_late(b_refresh_late)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;     // 0 cpu, 1 disk, 2 video
        logic        wr;
        logic        rd;
        logic [22:0] addr;
        logic [7:0]  wdata;
        logic [15:0] di;
        int          busy_n;
        logic [21:0] e_addr;
        logic [15:0] e_do;
        logic        e_lb;
        logic        e_ub;
        logic [15:0] e_rdata;
    } vec_t;

    typedef struct {
        logic [2:0]  cmd;      // {read, write, refresh}
        logic [21:0] addr;
        logic [15:0] dout;
        logic        lb;
        logic        ub;
    } cmd_exp_t;

    typedef struct {
        logic [2:0]  acks;     // {cpu, disk, vid}
        logic [7:0]  cpu_rd;
        logic [7:0]  disk_rd;
        logic [15:0] vid_rd;
    } ack_exp_t;

    cmd_exp_t cmd_q[$];
    ack_exp_t ack_q[$];
    cmd_exp_t mc;
    ack_exp_t ma;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   b_ref_cnt = 0;
    int   b_ack_cnt = 0;
    bit   mon_en = 1'b0;

    logic [7:0]  exp_cpu_rd = '0;
    logic [7:0]  exp_disk_rd = '0;
    logic [15:0] exp_vid_rd = '0;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b_sdram_refresh) b_ref_cnt <= b_ref_cnt + 1;
        if (b_cpu_ack) b_ack_cnt <= b_ack_cnt + 1;
    end

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sdram_read | sdram_write | sdram_refresh) begin
                if (cmd_q.size() == 0) begin
                    check("cmd_unexpected", {29'd0, sdram_read, sdram_write, sdram_refresh}, 32'd0);
                end else begin
                    mc = cmd_q.pop_front();
                    check("cmd_kind", {29'd0, sdram_read, sdram_write, sdram_refresh}, {29'd0, mc.cmd});
                    check("cmd_addr", {10'd0, sdram_addr}, {10'd0, mc.addr});
                    check("cmd_do", {16'd0, sdram_do}, {16'd0, mc.dout});
                    check("cmd_lanes", {30'd0, sdram_lb, sdram_ub}, {30'd0, mc.lb, mc.ub});
                end
            end
            if (cpu_ack | disk_ack | vid_ack) begin
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", {29'd0, cpu_ack, disk_ack, vid_ack}, 32'd0);
                end else begin
                    ma = ack_q.pop_front();
                    check("ack_port", {29'd0, cpu_ack, disk_ack, vid_ack}, {29'd0, ma.acks});
                    check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, ma.cpu_rd});
                    check("disk_rdata", {24'd0, disk_rdata}, {24'd0, ma.disk_rd});
                    check("vid_rdata", {16'd0, vid_rdata}, {16'd0, ma.vid_rd});
                    check("done_bus_clear", {8'd0, sdram_addr, sdram_lb, sdram_ub}, 32'd0);
                    check("done_do_clear", {16'd0, sdram_do}, 32'd0);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"}, {cpu_rdata, disk_rdata, vid_rdata}, 32'd0);
        check({tag, "_ctl"}, {23'd0, cpu_ack, disk_ack, vid_ack, sdram_read, sdram_write,
                              sdram_refresh, sdram_lb, sdram_ub, refresh_late}, 32'd0);
        check({tag, "_addr"}, {10'd0, sdram_addr}, 32'd0);
        check({tag, "_do"}, {16'd0, sdram_do}, 32'd0);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cpu_rd  = '0;
        exp_disk_rd = '0;
        exp_vid_rd  = '0;
    endtask

    // Strobe a slot with requests already driven, model the controller busy
    // window and wait for the ack. Returns in the HOLD cycle.
    task automatic slot_txn(input logic [15:0] di, input int busy_n, input logic [2:0] ack_bits);
        int  t0;
        int  lat;
        int  exp_lat;
        bit  got;
        sdram_di    = di;
        sdram_busy  = 1'b0;
        access_slot = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        access_slot = 1'b0;
        @(negedge clk);
        check("cmd_at_t1", {31'd0, (sdram_read | sdram_write | sdram_refresh)}, 32'd1);
        @(posedge clk); #1;
        access_slot = 1'b1;             // stray strobe in ARM must be ignored
        if (busy_n > 0) sdram_busy = 1'b1;
        @(posedge clk); #1;
        access_slot = 1'b0;
        if (busy_n <= 1) sdram_busy = 1'b0;
        for (int i = 1; i < busy_n; i++) begin
            @(posedge clk); #1;
        end
        sdram_busy = 1'b0;
        if (ack_bits != 3'b000) begin
            got = 1'b0;
            lat = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (cpu_ack | disk_ack | vid_ack) begin
                    got = 1'b1;
                    lat = cyc - t0;
                    break;
                end
            end
            check("ack_seen", {31'd0, got}, 32'd1);
            exp_lat = (busy_n + 3 > 4) ? busy_n + 3 : 4;
            check("ack_latency", lat, exp_lat);
            @(posedge clk); #1;
        end else begin
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        cmd_exp_t c;
        ack_exp_t a;
        case (v.port)
            0: begin cpu_read = v.rd; cpu_write = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata; end
            1: begin disk_read = v.rd; disk_write = v.wr; disk_addr = v.addr; disk_wdata = v.wdata; end
            default: begin vid_read = 1'b1; vid_addr = v.addr[21:0]; end
        endcase
        if (v.rd && !v.wr) begin
            case (v.port)
                0: exp_cpu_rd = v.e_rdata[7:0];
                1: exp_disk_rd = v.e_rdata[7:0];
                default: exp_vid_rd = v.e_rdata;
            endcase
        end
        c.cmd  = {v.rd & ~v.wr, v.wr, 1'b0};
        c.addr = v.e_addr;
        c.dout = v.e_do;
        c.lb   = v.e_lb;
        c.ub   = v.e_ub;
        cmd_q.push_back(c);
        a.acks    = (v.port == 0) ? 3'b100 : (v.port == 1) ? 3'b010 : 3'b001;
        a.cpu_rd  = exp_cpu_rd;
        a.disk_rd = exp_disk_rd;
        a.vid_rd  = exp_vid_rd;
        ack_q.push_back(a);
        slot_txn(v.di, v.busy_n, a.acks);
        cpu_read = 1'b0; cpu_write = 1'b0;
        disk_read = 1'b0; disk_write = 1'b0;
        vid_read = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push_cmd(input logic [2:0] cmd, input logic [21:0] addr, input logic [15:0] dout,
                            input logic lb, input logic ub);
        cmd_exp_t c;
        c.cmd = cmd; c.addr = addr; c.dout = dout; c.lb = lb; c.ub = ub;
        cmd_q.push_back(c);
    endtask

    task automatic push_ack(input logic [2:0] acks);
        ack_exp_t a;
        a.acks = acks; a.cpu_rd = exp_cpu_rd; a.disk_rd = exp_disk_rd; a.vid_rd = exp_vid_rd;
        ack_q.push_back(a);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t rv;
        bit   seen;
        int   r0;
        int   a0;
        logic [15:0] rr_di [4];

        //               port wr    rd    addr          wdata  di        busy e_addr         e_do      lb    ub    e_rdata
        vecs[0] = '{0, 1'b0, 1'b1, 23'h000003, 8'h00, 16'hA55A, 4, 22'h000001, 16'h0000, 1'b0, 1'b1, 16'h00A5};
        vecs[1] = '{1, 1'b1, 1'b0, 23'h000010, 8'h3C, 16'hFFFF, 0, 22'h000008, 16'h3C3C, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{1, 1'b0, 1'b1, 23'h000010, 8'h00, 16'h1234, 1, 22'h000008, 16'h0000, 1'b1, 1'b0, 16'h0034};
        vecs[3] = '{0, 1'b1, 1'b0, 23'h7FFFFF, 8'hC3, 16'h0000, 2, 22'h3FFFFF, 16'hC3C3, 1'b0, 1'b1, 16'h0000};
        vecs[4] = '{2, 1'b0, 1'b1, 23'h3FFFFF, 8'h00, 16'hBEEF, 3, 22'h3FFFFF, 16'h0000, 1'b1, 1'b1, 16'hBEEF};
        vecs[5] = '{0, 1'b1, 1'b1, 23'h000000, 8'h81, 16'h7777, 0, 22'h000000, 16'h8181, 1'b1, 1'b0, 16'h0000};
        vecs[6] = '{1, 1'b0, 1'b1, 23'h000001, 8'h00, 16'h5AA5, 0, 22'h000000, 16'h0000, 1'b0, 1'b1, 16'h005A};
        vecs[7] = '{2, 1'b0, 1'b1, 23'h000000, 8'h00, 16'h0001, 0, 22'h000000, 16'h0000, 1'b1, 1'b1, 16'h0001};
        vecs[8] = '{0, 1'b0, 1'b1, 23'h000002, 8'h00, 16'h7E00, 5, 22'h000001, 16'h0000, 1'b1, 1'b0, 16'h0000};

        reset_dut();
        check_all_zero("reset");
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset held three cycles while the CPU read sits in WAIT.
        mon_en = 1'b0;
        cpu_read = 1'b1; cpu_addr = 23'h000003;
        sdram_busy = 1'b0;
        access_slot = 1'b1;
        @(posedge clk); #1;
        access_slot = 1'b0;
        @(posedge clk); #1;
        sdram_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            seen = seen | cpu_ack | disk_ack | vid_ack;
        end
        check("rst_mid_no_ack", {31'd0, seen}, 32'd0);
        check_all_zero("rst_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        sdram_busy = 1'b0;
        exp_cpu_rd = '0; exp_disk_rd = '0; exp_vid_rd = '0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | cpu_ack | sdram_read | sdram_write | sdram_refresh;
        end
        check("rst_mid_quiet", {31'd0, seen}, 32'd0);
        @(posedge clk); #1;
        mon_en = 1'b1;
        rv = '{0, 1'b0, 1'b1, 23'h000003, 8'h00, 16'h6996, 0, 22'h000001, 16'h0000, 1'b0, 1'b1, 16'h0069};
        run_vec(rv);

        // Both byte ports requesting continuously: CPU, disk, CPU, disk.
        reset_dut();
        rr_di[0] = 16'hA1B2; rr_di[1] = 16'hC3D4; rr_di[2] = 16'hE5F6; rr_di[3] = 16'h0718;
        cpu_read = 1'b1;  cpu_addr = 23'h000100;
        disk_read = 1'b1; disk_addr = 23'h000201;
        for (int i = 0; i < 4; i++) begin
            if ((i % 2) == 0) begin
                exp_cpu_rd = rr_di[i][7:0];
                push_cmd(3'b100, 22'h000080, 16'h0000, 1'b1, 1'b0);
                push_ack(3'b100);
                slot_txn(rr_di[i], i, 3'b100);
            end else begin
                exp_disk_rd = rr_di[i][15:8];
                push_cmd(3'b100, 22'h000100, 16'h0000, 1'b0, 1'b1);
                push_ack(3'b010);
                slot_txn(rr_di[i], i, 3'b010);
            end
            @(posedge clk); #1;
        end
        cpu_read = 1'b0; disk_read = 1'b0;
        @(posedge clk); #1;

        // Refresh pending, video and CPU all at one slot.
        reset_dut();
        repeat (800) @(posedge clk);
        #1;
        vid_read = 1'b1; vid_addr = 22'h155555;
        cpu_read = 1'b1; cpu_addr = 23'h000006;
        push_cmd(3'b001, 22'h000000, 16'h0000, 1'b0, 1'b0);
        slot_txn(16'h0000, 2, 3'b000);
        @(posedge clk); #1;
        exp_vid_rd = 16'hCAFE;
        push_cmd(3'b100, 22'h155555, 16'h0000, 1'b1, 1'b1);
        push_ack(3'b001);
        slot_txn(16'hCAFE, 1, 3'b001);
        vid_read = 1'b0;
        @(posedge clk); #1;
        exp_cpu_rd = 8'h42;
        push_cmd(3'b100, 22'h000003, 16'h0000, 1'b1, 1'b0);
        push_ack(3'b100);
        slot_txn(16'h2442, 0, 3'b100);
        cpu_read = 1'b0;
        @(posedge clk); #1;
        check("cmd_q_empty", cmd_q.size(), 32'd0);
        check("ack_q_empty", ack_q.size(), 32'd0);

        // Refresh overrun on the 8-cycle instance while the controller stays busy.
        mon_en = 1'b0;
        reset_dut();
        check("b_reset_ctl", {26'd0, b_cpu_ack, b_sdram_read, b_sdram_write, b_sdram_refresh,
                              b_refresh_late, b_sdram_lb}, 32'd0);
        check("b_reset_rdata", {b_cpu_rdata, b_disk_rdata, b_vid_rdata}, 32'd0);
        r0 = b_ref_cnt;
        a0 = b_ack_cnt;
        cpu_read = 1'b1; cpu_addr = 23'h000004;
        access_slot = 1'b1;
        @(posedge clk); #1;
        access_slot = 1'b0;
        @(posedge clk); #1;
        sdram_busy = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("b_late_set", {31'd0, b_refresh_late}, 32'd1);
        check("b_no_ref_while_busy", b_ref_cnt - r0, 32'd0);
        sdram_busy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b_cpu_ack) begin
                seen = 1'b1;
                break;
            end
        end
        check("b_cpu_ack_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        cpu_read = 1'b0;
        @(posedge clk); #1;
        r0 = b_ref_cnt;
        access_slot = 1'b1;
        @(posedge clk); #1;
        access_slot = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("b_one_refresh", b_ref_cnt - r0, 32'd1);
        check("b_one_cpu_ack", b_ack_cnt - a0, 32'd1);
        check("b_late_sticky", {31'd0, b_refresh_late}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
